// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues single-word reads to a
// 1-cycle-latency instruction memory, buffers returned words in a small
// prefetch FIFO and presents them to decode on a valid/ready handshake.
// A redirect from execute flushes every in-flight and buffered instruction.
//
// FIFO_DEPTH must be a power of two (pointers wrap by natural overflow).
//
// state      | meaning
// -----------+-------------------------------------------------------------
// S_IDLE     | first cycle after reset release, no fetch issued
// S_RUN      | fetching while the FIFO has credit for another word
// S_REDIRECT | one quiet cycle after a redirect before fetching new path
module instr_fetch_unit #(
    parameter int                    ADDR_WIDTH = 16,
    parameter int                    DATA_WIDTH = 16,
    parameter int                    FIFO_DEPTH = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    output logic                  imem_req_o,
    output logic [ADDR_WIDTH-1:0] imem_addr_o,
    input  logic [DATA_WIDTH-1:0] imem_rdata_i,
    input  logic                  redirect_valid_i,
    input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
    output logic                  instr_valid_o,
    output logic [DATA_WIDTH-1:0] instr_o,
    output logic [ADDR_WIDTH-1:0] instr_pc_o,
    input  logic                  instr_ready_i
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_RUN      = 2'd1,
        S_REDIRECT = 2'd2
    } state_e;

    state_e                  state_q;
    logic [ADDR_WIDTH-1:0]   pc_q;
    logic                    inflight_q;
    logic [ADDR_WIDTH-1:0]   issued_pc_q;

    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [PTR_W-1:0]        rd_ptr_q, wr_ptr_q;
    logic [DATA_WIDTH-1:0]   fifo_data_q [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0]   fifo_pc_q   [FIFO_DEPTH];

    logic [CNT_W:0]          committed;
    logic                    credit_ok;
    logic                    issue;
    logic                    push;
    logic                    pop;
    logic                    not_empty;

    // Credit counts both buffered words and the one word still in flight,
    // so a returning word always finds a free FIFO slot.
    always_comb begin
        committed = {1'b0, cnt_q} + {{CNT_W{1'b0}}, inflight_q};
        credit_ok = committed < DEPTH_C;
        not_empty = cnt_q != '0;
        issue     = (state_q == S_RUN) && credit_ok && !redirect_valid_i;
        push      = inflight_q && !redirect_valid_i;
        pop       = not_empty && instr_ready_i && !redirect_valid_i;
    end

    assign imem_req_o    = issue;
    assign imem_addr_o   = pc_q;
    assign instr_valid_o = not_empty;
    assign instr_o       = not_empty ? fifo_data_q[rd_ptr_q] : '0;
    assign instr_pc_o    = not_empty ? fifo_pc_q[rd_ptr_q]   : '0;

    // Fetch control: state, PC and the single outstanding-request tracker.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            pc_q        <= RESET_PC;
            inflight_q  <= 1'b0;
            issued_pc_q <= '0;
        end else if (redirect_valid_i) begin
            state_q    <= S_REDIRECT;
            pc_q       <= redirect_pc_i;
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= issue;
            if (issue) begin
                pc_q        <= pc_q + ADDR_WIDTH'(1);
                issued_pc_q <= pc_q;
            end
            case (state_q)
                S_IDLE:     state_q <= S_RUN;
                S_REDIRECT: state_q <= S_RUN;
                S_RUN:      state_q <= S_RUN;
                default:    state_q <= S_IDLE;
            endcase
        end
    end

    // Occupancy next value; a simultaneous push and pop leaves it unchanged.
    always_comb begin
        cnt_d = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // FIFO pointers and occupancy; a redirect discards everything buffered.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q    <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
        end else if (redirect_valid_i) begin
            cnt_q    <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        end
    end

    // FIFO storage; contents are only observed through the gated head.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_data_q[wr_ptr_q] <= imem_rdata_i;
            fifo_pc_q[wr_ptr_q]   <= issued_pc_q;
        end
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Instruction fetch stage of the 16-bit CPU. Sits directly upstream of decode/execute inside the CPU core.
- Owns the program counter and issues word reads to a synchronous instruction memory with fixed 1-cycle read latency.
- Buffers returned instructions in a small prefetch FIFO and hands them to decode over a valid/ready handshake.
- Accepts branch/jump redirects from execute; a redirect flushes all wrong-path work.

Parameters:
- ADDR_WIDTH, 16, PC and instruction-memory word-address width.
- DATA_WIDTH, 16, instruction width.
- FIFO_DEPTH, 4, prefetch FIFO entries; must be a power of 2 and at least 2.
- RESET_PC, 16'h0000, PC value loaded at reset.

Ports:
- Clock  in  1  Single system clock; all state updates on the rising edge.
- Reset_n  in  1  Asynchronous, active-low reset.
- imem_req  out  1  Read request to instruction memory, this cycle.
- imem_addr  out  ADDR_WIDTH  Word address of the request; valid when imem_req=1.
- imem_rdata  in  DATA_WIDTH  Read data, valid exactly one cycle after an accepted imem_req.
- redirect_valid  in  1  Execute requests a PC change (taken branch/jump).
- redirect_pc  in  ADDR_WIDTH  New PC; sampled when redirect_valid=1.
- instr_valid  out  1  FIFO head holds a valid instruction.
- instr  out  DATA_WIDTH  Instruction at the FIFO head.
- instr_pc  out  ADDR_WIDTH  Address of instr.
- instr_ready  in  1  Decode accepts the head this cycle.

Behaviour:
Reset (async assert, Reset_n=0):
- pc=RESET_PC; FIFO empty (count=0); inflight=0; state=IDLE.
- Outputs: imem_req=0, instr_valid=0, instr=0, instr_pc=0.

FSM states:
- IDLE: entered on reset. Lasts exactly one cycle after Reset_n deasserts, with imem_req=0. Goes to RUN.
- RUN:
  - imem_req = (count + inflight < FIFO_DEPTH) and not redirect_valid. Here count is occupancy before this cycle's pop.
  - imem_addr = pc.
  - On an issued request: pc <= pc+1, modulo 2^ADDR_WIDTH (16'hFFFF wraps to 16'h0000); inflight <= 1.
  - If no request is issued, inflight <= 0.
- REDIRECT: entered on any cycle with redirect_valid=1, from IDLE or RUN.
  - At that edge: pc <= redirect_pc; FIFO cleared; inflight cleared.
  - imem_rdata arriving in the redirect cycle is discarded.
  - Spends one cycle with imem_req=0, then goes to RUN.
  - redirect_valid=1 while in REDIRECT restarts REDIRECT with the new redirect_pc. The last redirect wins.

Response capture:
- When inflight=1 and no redirect this cycle, push {imem_rdata, issued PC} into the FIFO at the clock edge.
- The issued PC is held in a 1-entry register alongside inflight.

Output handshake:
- instr_valid = (count>0); instr and instr_pc come from the FIFO head, forced to 0 when empty.
- Pop occurs when instr_valid & instr_ready & !redirect_valid.
- Simultaneous push and pop: count unchanged, order preserved.
- instr, instr_pc and instr_valid hold stable while instr_valid=1 and instr_ready=0.

Flow control:
- The credit rule guarantees a push never hits a full FIFO. Overflow is impossible by construction; the bench asserts it.

Latency:
- Issue at cycle t, data at t+1, instr_valid visible at t+2 (FIFO write at the end of t+1).
- Redirect at cycle t: REDIRECT at t+1 (no request), request of redirect_pc at t+2, instr_valid with instr_pc=redirect_pc at t+4.
- Steady state with instr_ready held at 1: one instruction per cycle.

Reset mid-operation:
- Async reset returns all state to reset values immediately, regardless of FIFO contents or an in-flight request.
- Any imem_rdata arriving after reset is ignored.

Test Plan:
- Reset release, RESET_PC=0, instr_ready=1, imem returns mem[a]=16'hA000+a -> first imem_req at cycle 2 after deassert; instr_valid with instr=16'hA000/pc=0 at cycle 4; then one instruction per cycle in PC order 0,1,2,3.
- instr_ready=0 for 10 cycles -> exactly FIFO_DEPTH=4 requests issued, count=4, no overflow, head stable at pc 0; release ready -> 4 pops then streaming resumes at pc 4 with no gap or duplicate.
- Redirect to 16'h0100 while the FIFO holds 3 entries and a request is in flight -> FIFO empty next cycle; no wrong-path instr_pc ever appears; first instr_pc=16'h0100 four cycles after redirect.
- Back-to-back redirects to 16'h0200 then 16'h0300 on consecutive cycles -> only pc 16'h0300 onward delivered.
- Redirect to 16'hFFFE with ready=1 -> instr_pc sequence FFFE, FFFF, 0000, 0001.
- Assert Reset_n=0 mid-stream with the FIFO full -> instr_valid and imem_req drop immediately (asynchronously); after release, fetch restarts from RESET_PC.
